id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 supported.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  ID holds a real instruction.
REQ-005 id_instr  input  32  raw RV32IM instruction word.
REQ-006 id_pc  input  32  PC of id_instr.
REQ-007 id_rs1_data  input  32  register-file read of rs1.
REQ-008 id_rs2_data  input  32  register-file read of rs2.
REQ-009 id_imm  input  32  sign-extended immediate.
REQ-010 flush  input  1  squash ID instruction (taken branch/jump).
REQ-011 stall_out  output  1  combinational; hold PC and IF/ID this cycle.
REQ-012 exmem_rd  input  5  EX/MEM destination; 0 = no write.
REQ-013 exmem_result  input  32  EX/MEM ALU result.
REQ-014 memwb_rd  input  5  MEM/WB destination; 0 = no write.
REQ-015 memwb_result  input  32  MEM/WB writeback value.
REQ-016 ex_valid  output  1  EX holds a real instruction.
REQ-017 ex_data1  output  32  ALU DATA1.
REQ-018 ex_data2  output  32  ALU DATA2.
REQ-019 ex_select  output  5  ALU SELECT.
REQ-020 ex_store_data  output  32  forwarded rs2 for stores.
REQ-021 ex_rd  output  5  EX destination; 0 when no writeback.
REQ-022 ex_mem_read  output  1  EX instruction is a load.
REQ-023 ex_mem_write  output  1  EX instruction is a store.

Function
REQ-024 SHALL register decoded id_instr at each edge: one-cycle latency ID->EX; ex_data1/ex_data2/ex_store_data are combinational from registered state plus forwarding inputs.
REQ-025 SHALL decode SELECT: funct3 000..111 (funct7=0) -> ADD 0, SLL 1, SLT 2, SLTU 3, XOR 4, SRL 5, OR 6, AND 7; funct7=0100000: SUB 16 (R only), SRA 17.
REQ-026 SHALL decode M (opcode 0110011, funct7 0000001) funct3 000..111 -> MUL 8, MULH 9, MULHSU 10, MULHU 11, DIV 12, DIVU 14, REM 13, REMU 15.
REQ-027 SHALL select ADD for load/store/LUI/AUIPC/JAL/JALR; branches: BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU.
REQ-028 SHALL source DATA1: rs1 normally, PC for AUIPC/JAL/JALR, 0 for LUI; DATA2: rs2 for R-type/branch, 4 for JAL/JALR, else id_imm.
REQ-029 SHALL set ex_rd=0 for store, branch, unknown opcode; unknown opcode otherwise captured as ADD bubble with ex_valid=1.
REQ-030 SHALL forward each register operand: EX/MEM when exmem_rd==rs!=0, else MEM/WB when memwb_rd==rs!=0, else registered file value; EX/MEM wins on double match.
REQ-031 SHALL assert stall_out when id_valid, ex_valid, ex_mem_read, ex_rd!=0, and ex_rd equals an rs the ID instruction actually reads (load-use).
REQ-032 SHALL on stall_out load a bubble (ex_valid=0, ex_rd=0, mem_read/write=0, select 0); ID instruction re-presented next cycle.
REQ-033 SHALL on flush load a bubble and deassert stall_out; flush beats stall and id_valid.
REQ-034 SHALL load a bubble when id_valid=0.

Reset
REQ-035 SHALL on RESET at edge clear all state: ex_valid 0, ex_select 0, ex_rd 0, ex_mem_read 0, ex_mem_write 0, operands 0; ex_data1/ex_data2/ex_store_data read 0; RESET beats flush/stall.
REQ-036 SHALL deassert stall_out while RESET is high.

Configuration
REQ-037 SHALL with ID_EX_FORWARDING_EN defined implement REQ-030 and REQ-031 as stated.
REQ-038 SHALL without ID_EX_FORWARDING_EN omit forwarding and assert stall_out on any RAW match of used rs!=0 against ex_rd (ex_valid) or exmem_rd; MEM/WB relies on write-first register file.

Verification
REQ-039 ADD x3,x1,x2 with rs1=5, rs2=7 -> next cycle ex_select 0, ex_data1 5, ex_data2 7, ex_rd 3.
REQ-040 exmem_rd=1 result 0xAA, memwb_rd=1 result 0xBB, SUB x4,x1,x0 -> ex_data1 0xAA, select 16; exmem_rd=0 -> 0xBB.
REQ-041 LW x5 in EX then ADD x6,x5,x5 in ID -> stall_out 1 one cycle, bubble, ADD captured next edge.
REQ-042 flush=1 with stall condition -> stall_out 0, ex_valid 0, ex_rd 0 next cycle.
REQ-043 RESET=1 mid-stream with DIVU x7 in ID -> all outputs 0 after edge; DIVU after release -> select 14.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32IM decode-to-execute pipeline register.
//   Decodes the ID instruction into an ALU select, operand sources, a
//   destination and load/store flags, and registers them for EX. ALU operands
//   and store data leave the stage combinationally, with optional forwarding.
//   Detects RAW hazards and raises a combinational stall.
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   id_*                  ID instruction, PC, register-file reads, immediate
//   flush                 squash the ID instruction (taken branch/jump)
//   stall_out             combinational: hold PC and IF/ID this cycle
//   exmem_rd/_result      EX/MEM destination and ALU result
//   memwb_rd/_result      MEM/WB destination and writeback value
//   ex_*                  EX-stage instruction: valid, operands, select, rd,
//                         store data, load/store flags
//
// Configuration
//   ID_EX_FORWARDING_EN   defined: forward from EX/MEM and MEM/WB and stall
//                         only on load-use. Undefined: no forwarding, stall on
//                         any RAW match against EX or EX/MEM; MEM/WB relies on
//                         a write-first register file.
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            flush,
  output logic            stall_out,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_data1,
  output logic [XLEN-1:0] ex_data2,
  output logic [4:0]      ex_select,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_mem_read,
  output logic            ex_mem_write
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [4:0] SEL_ADD  = 5'd0;
  localparam logic [4:0] SEL_SLL  = 5'd1;
  localparam logic [4:0] SEL_SLT  = 5'd2;
  localparam logic [4:0] SEL_SLTU = 5'd3;
  localparam logic [4:0] SEL_SRL  = 5'd5;
  localparam logic [4:0] SEL_SUB  = 5'd16;
  localparam logic [4:0] SEL_SRA  = 5'd17;

  // Registered EX state. fw*_idx/st_idx are non-zero only where the operand
  // really comes from that register, so x0 and non-register sources never
  // pick up a forwarded value.
  typedef struct packed {
    logic            valid;
    logic [4:0]      select;
    logic [4:0]      rd;
    logic            mem_read;
    logic            mem_write;
    logic [4:0]      fw1_idx;
    logic [4:0]      fw2_idx;
    logic [4:0]      st_idx;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] st_val;
  } ex_state_t;

  ex_state_t ex_q, ex_d, dec;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;
  logic       uses_rs1, uses_rs2;
  logic       op1_is_rs1, op2_is_rs2;
  logic       known;
  logic       hazard;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign funct3 = id_instr[14:12];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign funct7 = id_instr[31:25];

  // M-extension select codes (DIV/REM interleaved with their unsigned forms)
  function automatic logic [4:0] m_select(input logic [2:0] f3);
    case (f3)
      3'b000:  return 5'd8;
      3'b001:  return 5'd9;
      3'b010:  return 5'd10;
      3'b011:  return 5'd11;
      3'b100:  return 5'd12;
      3'b101:  return 5'd14;
      3'b110:  return 5'd13;
      default: return 5'd15;
    endcase
  endfunction

  // Instruction decode
  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.rd     = rd;
    dec.op1    = id_rs1_data;
    dec.op2    = id_imm;
    dec.st_val = id_rs2_data;
    dec.select = SEL_ADD;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    op1_is_rs1 = 1'b0;
    op2_is_rs2 = 1'b0;
    known      = 1'b1;

    case (opcode)
      OP_R: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        op1_is_rs1 = 1'b1;
        op2_is_rs2 = 1'b1;
        dec.op2    = id_rs2_data;
        case (funct7)
          7'b0000000: dec.select = {2'b00, funct3};
          7'b0000001: dec.select = m_select(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)      dec.select = SEL_SUB;
            else if (funct3 == 3'b101) dec.select = SEL_SRA;
            else                       known = 1'b0;
          end
          default: known = 1'b0;
        endcase
      end
      OP_IMM: begin
        uses_rs1   = 1'b1;
        op1_is_rs1 = 1'b1;
        if (funct3 == 3'b101) dec.select = funct7[5] ? SEL_SRA : SEL_SRL;
        else                  dec.select = {2'b00, funct3};
      end
      OP_LOAD: begin
        uses_rs1     = 1'b1;
        op1_is_rs1   = 1'b1;
        dec.mem_read = 1'b1;
      end
      OP_STORE: begin
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        op1_is_rs1    = 1'b1;
        dec.mem_write = 1'b1;
        dec.rd        = 5'd0;
      end
      OP_BRANCH: begin
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        op1_is_rs1 = 1'b1;
        op2_is_rs2 = 1'b1;
        dec.op2    = id_rs2_data;
        dec.rd     = 5'd0;
        case (funct3[2:1])
          2'b00:   dec.select = SEL_SUB;
          2'b10:   dec.select = SEL_SLT;
          2'b11:   dec.select = SEL_SLTU;
          default: known = 1'b0;
        endcase
      end
      OP_LUI:   dec.op1 = '0;
      OP_AUIPC: dec.op1 = id_pc;
      OP_JAL: begin
        dec.op1 = id_pc;
        dec.op2 = XLEN'(4);
      end
      OP_JALR: begin
        // rs1 feeds the jump target elsewhere; the ALU computes the link
        uses_rs1 = 1'b1;
        dec.op1  = id_pc;
        dec.op2  = XLEN'(4);
      end
      default: known = 1'b0;
    endcase

    dec.fw1_idx = op1_is_rs1 ? rs1 : 5'd0;
    dec.fw2_idx = op2_is_rs2 ? rs2 : 5'd0;
    dec.st_idx  = uses_rs2 ? rs2 : 5'd0;

    // Unknown encodings travel as a valid ADD with no side effects
    if (!known) begin
      dec       = '0;
      dec.valid = 1'b1;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
    end
  end

`ifdef ID_EX_FORWARDING_EN
  // Only a load in EX cannot be forwarded in time
  always_comb begin
    hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
             ((uses_rs1 && (rs1 == ex_q.rd)) || (uses_rs2 && (rs2 == ex_q.rd)));
  end

  function automatic logic [XLEN-1:0] fwd(input logic [4:0]      idx,
                                          input logic [XLEN-1:0] file_val,
                                          input logic [4:0]      m_rd,
                                          input logic [XLEN-1:0] m_val,
                                          input logic [4:0]      w_rd,
                                          input logic [XLEN-1:0] w_val);
    if ((idx != 5'd0) && (idx == m_rd))      return m_val;
    else if ((idx != 5'd0) && (idx == w_rd)) return w_val;
    else                                     return file_val;
  endfunction

  // Operand forwarding, EX/MEM has priority over MEM/WB
  always_comb begin
    ex_data1      = fwd(ex_q.fw1_idx, ex_q.op1, exmem_rd, exmem_result,
                        memwb_rd, memwb_result);
    ex_data2      = fwd(ex_q.fw2_idx, ex_q.op2, exmem_rd, exmem_result,
                        memwb_rd, memwb_result);
    ex_store_data = fwd(ex_q.st_idx, ex_q.st_val, exmem_rd, exmem_result,
                        memwb_rd, memwb_result);
  end
`else
  logic unused_fwd;

  // Without forwarding, any pending writer in EX or EX/MEM blocks the reader
  always_comb begin
    hazard = 1'b0;
    if (ex_q.valid && (ex_q.rd != 5'd0) &&
        ((uses_rs1 && (rs1 == ex_q.rd)) || (uses_rs2 && (rs2 == ex_q.rd))))
      hazard = 1'b1;
    if ((exmem_rd != 5'd0) &&
        ((uses_rs1 && (rs1 == exmem_rd)) || (uses_rs2 && (rs2 == exmem_rd))))
      hazard = 1'b1;
  end

  always_comb begin
    ex_data1      = ex_q.op1;
    ex_data2      = ex_q.op2;
    ex_store_data = ex_q.st_val;
  end

  assign unused_fwd = ^{exmem_result, memwb_rd, memwb_result,
                        ex_q.fw1_idx, ex_q.fw2_idx, ex_q.st_idx};
`endif

  // Flush and reset both suppress the stall
  assign stall_out = !RESET && !flush && id_valid && hazard;

  // Next EX state: bubble on flush, stall or empty ID
  always_comb begin
    ex_d = dec;
    if (flush || stall_out || !id_valid) ex_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign ex_valid     = ex_q.valid;
  assign ex_select    = ex_q.select;
  assign ex_rd        = ex_q.rd;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;

endmodule
